// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared types and constants for the data-cache DRAM block controller.
// The same enum also drives the debug state port.
package dcache_mem_ctrl_pkg;
  localparam int AWIDTH_DEF = 23;
  localparam int DWIDTH_DEF = 128;
  localparam int BLK_OFFSET = 4;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WB_GAP,
    RF,
    RESP
  } state_t;
endpackage

// File: rtl/dcache_mem_ctrl_wait_timer.sv
// Loadable up-counter bounding how long a DRAM request may wait for mem_ready.
// hit is high while the count equals TIMEOUT-1.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          hit
);
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dcache_mem_ctrl.sv
// Miss handler: optional victim write-back, one-cycle gap, block refill, response.
// All outputs are registered; dbg_state exposes the FSM for checkers.
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dirty,
  input  logic [AWIDTH-1:0] req_wb_addr,
  input  logic [DWIDTH-1:0] req_wb_data,
  input  logic [AWIDTH-1:0] req_rf_addr,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  output state_t            dbg_state
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is only ever high in IDLE.
  state_t            state;
  logic [AWIDTH-1:0] rf_addr_q;
  logic              accept;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_hit;

  assign accept    = req_valid && req_ready && (state == IDLE);
  assign tmr_clr   = accept || (state == WB_GAP);
  assign tmr_en    = (state == WB) || (state == RF);
  assign dbg_state = state;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (tmr_en),
    .hit      (tmr_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_addr_q <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rf_addr_q <= req_rf_addr;
            if (req_dirty) begin
              state     <= WB;
              mem_wren  <= 1'b1;
              mem_addr  <= req_wb_addr;
              mem_wdata <= req_wb_data;
            end else begin
              state    <= RF;
              mem_rden <= 1'b1;
              mem_addr <= req_rf_addr;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WB: begin
          if (mem_ready) begin
            state    <= WB_GAP;
            mem_wren <= 1'b0;
          end else if (tmr_hit) begin
            state     <= IDLE;
            mem_wren  <= 1'b0;
            rsp_err   <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        // Both requests stay low here so the DRAM sees a clean request edge.
        WB_GAP: begin
          state    <= RF;
          mem_rden <= 1'b1;
          mem_addr <= rf_addr_q;
        end
        RF: begin
          if (mem_ready) begin
            state     <= RESP;
            mem_rden  <= 1'b0;
            rsp_data  <= mem_rdata;
            rsp_valid <= 1'b1;
          end else if (tmr_hit) begin
            state     <= IDLE;
            mem_rden  <= 1'b0;
            rsp_err   <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with a simple 4-edge-latency DRAM model.
module tb_dcache_mem_ctrl;
  import dcache_mem_ctrl_pkg::*;

  localparam int AW = 23;
  localparam int DW = 128;
  localparam logic [DW-1:0] D10 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D21 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] D31 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FEED_FACE;
  localparam logic [DW-1:0] DA5 = {16{8'hA5}};

  logic          clk, rst;
  logic          req_valid, req_ready, req_dirty;
  logic [AW-1:0] req_wb_addr, req_rf_addr;
  logic [DW-1:0] req_wb_data;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          mem_wren, mem_rden, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_t        dbg_state;

  dcache_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty),
    .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_rf_addr(req_rf_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DRAM model ----------------
  logic [DW-1:0] mem_model [256];
  logic [3:0]    dcnt;
  logic          ready_en;

  always @(posedge clk) begin
    if (rst) begin
      dcnt      <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mem_model[8'h10] <= D10;
      mem_model[8'h21] <= D21;
      mem_model[8'h31] <= D31;
      mem_model[8'h20] <= '0;
    end else if (mem_wren || mem_rden) begin
      dcnt <= dcnt + 1'b1;
      if (dcnt == 4'd3 && ready_en) begin
        mem_ready <= 1'b1;
        if (mem_wren) mem_model[mem_addr[7:0]] <= mem_wdata;
        else          mem_rdata <= mem_model[mem_addr[7:0]];
      end else begin
        mem_ready <= 1'b0;
      end
    end else begin
      dcnt      <= '0;
      mem_ready <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  int            wren_cnt = 0, rden_cnt = 0, excl_viol = 0, stab_viol = 0;
  int            last_wren_cyc = 0, rden_rise_cyc = 0;
  logic          prev_held = 1'b0, prev_rden = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_held <= 1'b0;
      prev_rden <= 1'b0;
    end else begin
      if (mem_wren && mem_rden) excl_viol <= excl_viol + 1;
      if (mem_wren) begin
        wren_cnt      <= wren_cnt + 1;
        last_wren_cyc <= cyc;
      end
      if (mem_rden) begin
        rden_cnt <= rden_cnt + 1;
        if (!prev_rden) rden_rise_cyc <= cyc;
      end
      if (prev_held && (mem_wren || mem_rden) &&
          (mem_addr != prev_addr || (mem_wren && mem_wdata != prev_wdata)))
        stab_viol <= stab_viol + 1;
      prev_held  <= mem_wren || mem_rden;
      prev_rden  <= mem_rden;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int c0 = 0;
  int wren0 = 0, rden0 = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic dirty, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                       input logic [AW-1:0] rfa, input logic hold_valid);
    bit ok;
    @(negedge clk);
    req_dirty   = dirty;
    req_wb_addr = wba;
    req_wb_data = wbd;
    req_rf_addr = rfa;
    req_valid   = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("accept_wait", 0, 1);
    @(posedge clk);
    #1;
    c0    = cyc;
    wren0 = wren_cnt;
    rden0 = rden_cnt;
    if (!hold_valid) begin
      req_valid   = 1'b0;
      req_dirty   = 1'b1;
      req_wb_addr = '1;
      req_wb_data = '1;
      req_rf_addr = '1;
    end
  endtask

  task automatic wait_done(output int lat, output logic saw_valid, output logic saw_err);
    lat       = -1;
    saw_valid = 1'b0;
    saw_err   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || rsp_err) begin
        lat       = cyc - c0;
        saw_valid = rsp_valid;
        saw_err   = rsp_err;
        if (rsp_valid) begin
          if (exp_q.size() > 0) check_eq("rsp_data", rsp_data, exp_q.pop_front());
          else                  check_eq("unexpected_rsp", 1, 0);
        end
        break;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int   lat, r1;
  logic sv, se;

  initial begin
    rst = 1'b1; ready_en = 1'b1;
    req_valid = 1'b0; req_dirty = 1'b0;
    req_wb_addr = '0; req_wb_data = '0; req_rf_addr = '0;
    #12;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_mem_wren",  mem_wren,  0);
    check_eq("rst_mem_rden",  mem_rden,  0);
    check_eq("rst_mem_addr",  mem_addr,  0);
    check_eq("rst_rsp_data",  rsp_data,  0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", req_ready, 1);
    check_eq("post_rst_state", dbg_state, IDLE);

    // clean miss
    exp_q.push_back(D10);
    issue(1'b0, '0, '0, 23'h10, 1'b0);
    wait_done(lat, sv, se);
    check_eq("clean_lat",   lat, 5);
    check_eq("clean_valid", sv, 1);
    check_eq("clean_rden_cycles", rden_cnt - rden0, 5);
    check_eq("clean_wren_cycles", wren_cnt - wren0, 0);

    // dirty miss
    exp_q.push_back(D21);
    issue(1'b1, 23'h20, DA5, 23'h21, 1'b0);
    wait_done(lat, sv, se);
    check_eq("dirty_lat",   lat, 11);
    check_eq("dirty_wb_mem", mem_model[8'h20], DA5);
    check_eq("dirty_gap",   rden_rise_cyc - last_wren_cyc - 1, 1);
    check_eq("dirty_wren_cycles", wren_cnt - wren0, 5);

    // back-to-back with req_valid held; second request uses inputs present at re-acceptance
    @(negedge clk);
    exp_q.push_back(D10);
    exp_q.push_back(D31);
    issue(1'b0, '0, '0, 23'h10, 1'b1);
    req_rf_addr = 23'h31;
    wait_done(lat, sv, se);
    check_eq("b2b_first_lat", lat, 5);
    r1 = cyc;
    check_eq("b2b_ready_in_resp", req_ready, 0);
    for (int i = 0; i < 10; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    req_valid = 1'b0;
    check_eq("b2b_reaccept_cycle", c0 - r1, 2);
    wait_done(lat, sv, se);
    check_eq("b2b_second_lat", lat, 5);

    // timeout: DRAM never answers
    @(negedge clk);
    ready_en = 1'b0;
    issue(1'b0, '0, '0, 23'h10, 1'b0);
    wait_done(lat, sv, se);
    check_eq("to_lat",   lat, 16);
    check_eq("to_err",   se, 1);
    check_eq("to_valid", sv, 0);
    check_eq("to_rden",  mem_rden, 0);
    @(negedge clk);
    check_eq("to_req_ready", req_ready, 1);
    check_eq("to_err_pulse", rsp_err, 0);
    check_eq("to_no_valid",  rsp_valid, 0);
    ready_en = 1'b1;

    // reset in the middle of a write-back
    issue(1'b1, 23'h20, DA5, 23'h21, 1'b0);
    @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_wren",  mem_wren, 0);
    check_eq("mid_rst_addr",  mem_addr, 0);
    check_eq("mid_rst_wdata", mem_wdata, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    check_eq("mid_rst_state", dbg_state, IDLE);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_req_ready", req_ready, 1);
    exp_q.push_back(D31);
    issue(1'b0, '0, '0, 23'h31, 1'b0);
    wait_done(lat, sv, se);
    check_eq("after_rst_lat", lat, 5);

    // bus-wide properties
    @(negedge clk);
    check_eq("excl_wren_rden", excl_viol, 0);
    check_eq("req_stability",  stab_viol, 0);
    check_eq("exp_q_empty",    exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
